// File: rtl/issue_scoreboard.sv
// Issue controller: per-register pending-write scoreboard, RAW/saturation
// stalls, and a hold on issue behind control transfers until resolution.
module issue_scoreboard #(
    parameter int WB_MAX = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [0:31] dec_insn,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        branch_resolved,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic [31:0] busy_mask,
    output logic        br_wait,
    output logic        wb_error
);

    typedef enum logic {RUN, BR_WAIT} state_t;

    localparam logic [1:0] MAX = WB_MAX[1:0];

    state_t     state, state_nxt;
    logic [1:0] count   [32];
    logic [1:0] cnt_nxt [32];
    logic [31:0] busy_nxt;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd, dest;
    logic       use_rs, use_rt, is_ctrl;
    logic       hazard, sat, err_set;
    logic       unused_bits;

    assign opcode = dec_insn[0:5];
    assign rs     = dec_insn[6:10];
    assign rt     = dec_insn[11:15];
    assign rd     = dec_insn[16:20];
    assign unused_bits = ^dec_insn[21:31];

    always_comb begin
        dest    = 5'd0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        is_ctrl = 1'b0;
        unique case (opcode)
            6'b000000: begin
                dest   = rd;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'b001001, 6'b001010, 6'b001101, 6'b100011: begin
                dest   = rt;
                use_rs = 1'b1;
            end
            6'b001111: dest = rt;
            6'b101011: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'b000100, 6'b000101: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                is_ctrl = 1'b1;
            end
            6'b000111, 6'b000110, 6'b000001: begin
                use_rs  = 1'b1;
                is_ctrl = 1'b1;
            end
            6'b000010: is_ctrl = 1'b1;
            default: ;
        endcase
    end

    // Register 0 never holds a count, so its scoreboard entry is always 0.
    assign hazard = (use_rs && rs != 5'd0 && count[rs] != 2'd0)
                 || (use_rt && rt != 5'd0 && count[rt] != 2'd0);
    assign sat    = dest != 5'd0 && count[dest] == MAX;
    assign stall  = dec_valid & (hazard | sat | (state == BR_WAIT));
    assign issue  = dec_valid & ~stall & ~flush;

    assign err_set = wb_valid && wb_rd != 5'd0 && count[wb_rd] == 2'd0;

    always_comb begin
        cnt_nxt[0]  = 2'd0;
        busy_nxt    = '0;
        for (int r = 1; r < 32; r++) begin
            logic inc, dec;
            inc = issue && dest == 5'(r);
            dec = wb_valid && wb_rd == 5'(r) && count[r] != 2'd0;
            cnt_nxt[r] = count[r];
            if (inc && !dec)
                cnt_nxt[r] = count[r] + 2'd1;
            else if (dec && !inc)
                cnt_nxt[r] = count[r] - 2'd1;
            busy_nxt[r] = cnt_nxt[r] != 2'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = RUN;
        else if (state == RUN && issue && is_ctrl)
            state_nxt = BR_WAIT;
        else if (state == BR_WAIT && branch_resolved)
            state_nxt = RUN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            busy_mask <= '0;
            wb_error  <= 1'b0;
            for (int r = 0; r < 32; r++)
                count[r] <= 2'd0;
        end else begin
            state     <= state_nxt;
            busy_mask <= busy_nxt;
            wb_error  <= wb_error | err_set;
            for (int r = 0; r < 32; r++)
                count[r] <= cnt_nxt[r];
        end
    end

    assign br_wait = (state == BR_WAIT);

endmodule
